dual_issue_dispatch: RTL and testbench
======================================

Name: dual_issue_dispatch

Overview:
- Issue stage of the superscalar core. Accepts an instruction pair from fetch and routes each instruction to the ALU subpipeline or the memory subpipeline.
- A 32-entry register scoreboard blocks RAW and WAW hazards. Entries are set at issue and cleared by the subpipelines' write-back reports (regmuxout / busW side).
- The taken-branch signal from the ALU subpipeline flushes the pair buffer.

Parameters:
- PC_STEP, 4, byte distance between slot0 and slot1 PCs
- CNT_W, 16, width of the issue statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch presents a pair
- fetch_pc  in  32  PC of instr0; instr1 is at fetch_pc+PC_STEP
- fetch_instr0  in  32  older instruction
- fetch_instr1  in  32  younger instruction
- fetch_ready  out  1  pair accepted this cycle when fetch_valid && fetch_ready
- alu_valid  out  1  ALU-pipe issue strobe (registered)
- alu_pc  out  32  feeds IDpc of the ALU subpipeline
- alu_instr  out  32  feeds IDinstruction of the ALU subpipeline
- mem_valid  out  1  memory-pipe issue strobe (registered)
- mem_pc  out  32  PC for the memory pipe
- mem_instr  out  32  instruction for the memory pipe
- alu_wb_en  in  1  ALU pipe write-back (RegWr at WB)
- alu_wb_addr  in  5  ALU pipe destination (regmuxout[4:0])
- mem_wb_en  in  1  memory pipe write-back
- mem_wb_addr  in  5  memory pipe destination
- branch_taken  in  1  branch_ctrl from the ALU pipe; flush
- issue_cnt  out  CNT_W  instructions issued, wraps
- dual_cnt  out  CNT_W  cycles with two issues, wraps

Behaviour:
- Reset (async, rst_n=0): all outputs, the buffer valids v0/v1, the scoreboard and the counters go to 0. fetch_ready=1 after release.
- Decode:
  - Opcode 0x23 (lw) and 0x2B (sw) go to the MEM class. All others go to the ALU class.
  - Destination is rd [15:11] for opcode 0, rt [20:16] for lw and I-type ALU ops, and none for sw, beq (0x04), bne (0x05) and bgtz (0x07).
  - Sources are rs, plus rt for R-type, sw, beq and bne. Register $0 is never busy and never marked.
- Pair buffer: slots s0 (older) and s1 with v0/v1.
  - A fetch handshake loads both slots with v0=v1=1.
  - fetch_ready=1 only when the buffer will be empty at the end of the current cycle, meaning all valid slots issue this cycle, and branch_taken=0.
- Hazards:
  - Checks use the registered scoreboard only. A write-back in cycle N releases the register for an issue check in cycle N+1.
  - A slot is hazarded if any of its sources or its destination is busy.
- s0 issue rules:
  - If v1=0, s1 is already gone and s0 is the only candidate.
  - s0 issues if v0, it is not hazarded, and branch_taken=0.
- s1 issue rules:
  - If s0 is already issued, s1 issues alone under the same rule as s0.
  - If s0 issues this cycle, s1 co-issues only if all of these hold:
    - s1 is a different class from s0;
    - s0 is not a branch;
    - s1 has no source or destination equal to s0's destination;
    - s1 is not hazarded.
  - Otherwise s1 waits.
  - s1 never issues before s0: strictly in order.
- Output timing:
  - Issued instructions appear on alu_*/mem_* the next cycle.
  - alu_valid and mem_valid are one-cycle pulses. Cycles with no issue drive valid=0 and hold the previous pc/instr.
  - No backpressure from the subpipes: each accepts one instruction per cycle.
- Scoreboard:
  - Issue sets busy[dest].
  - A write-back clears busy[addr] when its en=1 and addr≠0.
  - A set and a clear on the same register in the same cycle: the set wins.
- Flush (branch_taken=1):
  - v0 and v1 are cleared at the clock edge. No issue occurs that cycle and fetch_ready=0.
  - Instructions already issued are not recalled. Their scoreboard bits clear normally on write-back.
- Counters:
  - issue_cnt adds 0, 1 or 2 per cycle.
  - dual_cnt increments on cycles with two issues.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Reset mid-issue: assert rst_n=0 asynchronously while v0=1 and a scoreboard bit is set → outputs, counters and busy all read 0 immediately; fetch_ready=1 after release.
- Pair lw $8,0($1) + add $9,$2,$3 at pc 0x40 → next cycle mem_valid=1 with mem_pc=0x40, and alu_valid=1 with alu_pc=0x44; dual_cnt=1, issue_cnt=2, busy[8]=busy[9]=1.
- Pair add $5,$1,$2 + sub $6,$5,$3 → add issues; sub is held until alu_wb_en=1 with addr=5, then issues the cycle after the write-back; fetch_ready stays 0 until then.
- Pair add + or (both ALU, independent) → two consecutive alu_valid pulses in order with pc 0x0 then 0x4; dual_cnt unchanged.
- Pair beq + lw with branch_taken=1 pulsed the cycle after beq issues → lw never issues (mem_valid stays 0); fetch_ready=0 during the flush cycle, then 1.
- alu_wb_en (addr 7) in the same cycle as issue of addi $7 → busy[7]=1 afterwards; write to $0 (add $0,...) never sets busy.

Source files
------------

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: holds a fetched instruction pair and issues it in order
// to the ALU and memory subpipelines, with a 32-entry busy scoreboard for RAW/WAW.

module dispatch_decode (
  input  logic [31:0] instr,
  output logic        is_mem,
  output logic        is_br,
  output logic [4:0]  dst,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b
);
  logic [5:0] op;

  // Register $0 stands for "no operand": it is never marked busy, so it never hazards.
  always_comb begin
    op     = instr[31:26];
    is_mem = (op == 6'h23) || (op == 6'h2B);
    is_br  = (op == 6'h04) || (op == 6'h05) || (op == 6'h07);
    src_a  = instr[25:21];
    src_b  = ((op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05)) ?
             instr[20:16] : 5'd0;
    if (op == 6'h00)
      dst = instr[15:11];
    else if ((op == 6'h2B) || is_br)
      dst = 5'd0;
    else
      dst = instr[20:16];
  end
endmodule

module dual_issue_dispatch #(
  parameter int PC_STEP = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instr0,
  input  logic [31:0]      fetch_instr1,
  output logic             fetch_ready,
  output logic             alu_valid,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_instr,
  output logic             mem_valid,
  output logic [31:0]      mem_pc,
  output logic [31:0]      mem_instr,
  input  logic             alu_wb_en,
  input  logic [4:0]       alu_wb_addr,
  input  logic             mem_wb_en,
  input  logic [4:0]       mem_wb_addr,
  input  logic             branch_taken,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] dual_cnt
);
  localparam int NSLOT = 2;

  logic [NSLOT-1:0]            v_q, v_d;
  logic [31:0]                 pc_q, pc_d;
  logic [NSLOT-1:0][31:0]      instr_q, instr_d;
  logic [31:0]                 busy_q, busy_d;
  logic                        alu_valid_q, alu_valid_d, mem_valid_q, mem_valid_d;
  logic [31:0]                 alu_pc_q, alu_pc_d, alu_instr_q, alu_instr_d;
  logic [31:0]                 mem_pc_q, mem_pc_d, mem_instr_q, mem_instr_d;
  logic [CNT_W-1:0]            issue_cnt_q, issue_cnt_d, dual_cnt_q, dual_cnt_d;

  logic [NSLOT-1:0]            is_mem, is_br, haz, iss;
  logic [NSLOT-1:0][4:0]       dst, src_a, src_b;
  logic [NSLOT-1:0][31:0]      slot_pc;
  logic                        dep;
  logic [31:0]                 set_m, clr_m;

  assign slot_pc[0] = pc_q;
  assign slot_pc[1] = pc_q + 32'(PC_STEP);

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    dispatch_decode u_dec (
      .instr (instr_q[g]),
      .is_mem(is_mem[g]),
      .is_br (is_br[g]),
      .dst   (dst[g]),
      .src_a (src_a[g]),
      .src_b (src_b[g])
    );
    assign haz[g] = busy_q[src_a[g]] | busy_q[src_b[g]] | busy_q[dst[g]];
  end

  // s1 depending on s0's result cannot co-issue even though the scoreboard is still clear.
  assign dep = (dst[0] != 5'd0) &&
               ((src_a[1] == dst[0]) || (src_b[1] == dst[0]) || (dst[1] == dst[0]));

  always_comb begin
    iss[0] = v_q[0] & ~haz[0] & ~branch_taken;
    if (v_q[0])
      iss[1] = iss[0] & v_q[1] & (is_mem[0] ^ is_mem[1]) & ~is_br[0] & ~dep & ~haz[1];
    else
      iss[1] = v_q[1] & ~haz[1] & ~branch_taken;
  end

  assign fetch_ready = ~branch_taken & (~v_q[0] | iss[0]) & (~v_q[1] | iss[1]);

  always_comb begin
    v_d         = v_q & ~iss;
    pc_d        = pc_q;
    instr_d     = instr_q;
    alu_valid_d = 1'b0;
    alu_pc_d    = alu_pc_q;
    alu_instr_d = alu_instr_q;
    mem_valid_d = 1'b0;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    set_m       = '0;
    clr_m       = '0;
    if (branch_taken) begin
      v_d = '0;
    end else if (fetch_valid && fetch_ready) begin
      v_d     = '1;
      pc_d    = fetch_pc;
      instr_d = {fetch_instr1, fetch_instr0};
    end
    for (int s = 0; s < NSLOT; s++) begin
      if (iss[s]) begin
        if (is_mem[s]) begin
          mem_valid_d = 1'b1;
          mem_pc_d    = slot_pc[s];
          mem_instr_d = instr_q[s];
        end else begin
          alu_valid_d = 1'b1;
          alu_pc_d    = slot_pc[s];
          alu_instr_d = instr_q[s];
        end
        set_m[dst[s]] = 1'b1;
      end
    end
    if (alu_wb_en) clr_m[alu_wb_addr] = 1'b1;
    if (mem_wb_en) clr_m[mem_wb_addr] = 1'b1;
    busy_d      = (busy_q & ~clr_m) | set_m;
    busy_d[0]   = 1'b0;
    issue_cnt_d = issue_cnt_q + CNT_W'(iss[0]) + CNT_W'(iss[1]);
    dual_cnt_d  = dual_cnt_q + CNT_W'(iss[0] & iss[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      busy_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_pc_q    <= '0;
      alu_instr_q <= '0;
      mem_valid_q <= 1'b0;
      mem_pc_q    <= '0;
      mem_instr_q <= '0;
      issue_cnt_q <= '0;
      dual_cnt_q  <= '0;
    end else begin
      v_q         <= v_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      busy_q      <= busy_d;
      alu_valid_q <= alu_valid_d;
      alu_pc_q    <= alu_pc_d;
      alu_instr_q <= alu_instr_d;
      mem_valid_q <= mem_valid_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
      issue_cnt_q <= issue_cnt_d;
      dual_cnt_q  <= dual_cnt_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_pc    = alu_pc_q;
  assign alu_instr = alu_instr_q;
  assign mem_valid = mem_valid_q;
  assign mem_pc    = mem_pc_q;
  assign mem_instr = mem_instr_q;
  assign issue_cnt = issue_cnt_q;
  assign dual_cnt  = dual_cnt_q;
endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Bench for dual_issue_dispatch: directed pair scenarios plus random traffic,
// checked every cycle against a queue-based model of the pair buffer and scoreboard.

module tb_dual_issue_dispatch;
  localparam int CNT_W = 4;

  logic             clk, rst_n;
  logic             fetch_valid, fetch_ready;
  logic [31:0]      fetch_pc, fetch_instr0, fetch_instr1;
  logic             alu_valid, mem_valid;
  logic [31:0]      alu_pc, alu_instr, mem_pc, mem_instr;
  logic             alu_wb_en, mem_wb_en, branch_taken;
  logic [4:0]       alu_wb_addr, mem_wb_addr;
  logic [CNT_W-1:0] issue_cnt, dual_cnt;

  dual_issue_dispatch #(.PC_STEP(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_ready(fetch_ready),
    .alu_valid(alu_valid), .alu_pc(alu_pc), .alu_instr(alu_instr),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_instr(mem_instr),
    .alu_wb_en(alu_wb_en), .alu_wb_addr(alu_wb_addr),
    .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr),
    .branch_taken(branch_taken),
    .issue_cnt(issue_cnt), .dual_cnt(dual_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t             q[$];
  logic [31:0]      m_busy;
  logic             e_av, e_mv;
  logic [31:0]      e_apc, e_ai, e_mpc, e_mi;
  logic [CNT_W-1:0] e_ic, e_dc;

  function automatic logic [5:0] f_op(input logic [31:0] i); return i[31:26]; endfunction
  function automatic logic f_mem(input logic [31:0] i);
    return f_op(i) == 6'h23 || f_op(i) == 6'h2B;
  endfunction
  function automatic logic f_br(input logic [31:0] i);
    return f_op(i) == 6'h04 || f_op(i) == 6'h05 || f_op(i) == 6'h07;
  endfunction
  function automatic logic f_use_rt(input logic [31:0] i);
    return f_op(i) == 6'h00 || f_op(i) == 6'h2B || f_op(i) == 6'h04 || f_op(i) == 6'h05;
  endfunction
  function automatic logic [4:0] f_dst(input logic [31:0] i);
    if (f_op(i) == 6'h00) return i[15:11];
    if (f_op(i) == 6'h2B || f_br(i)) return 5'd0;
    return i[20:16];
  endfunction
  function automatic logic f_reads(input logic [31:0] i, input logic [4:0] r);
    return (r != 0) && (i[25:21] == r || (f_use_rt(i) && i[20:16] == r));
  endfunction
  function automatic logic f_hz(input logic [31:0] i);
    logic h;
    h = m_busy[i[25:21]] | m_busy[f_dst(i)];
    if (f_use_rt(i)) h = h | m_busy[i[20:16]];
    return h;
  endfunction
  function automatic logic f_pair_ok(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] d;
    d = f_dst(a);
    if (f_mem(a) == f_mem(b) || f_br(a)) return 1'b0;
    if (d != 0 && (f_reads(b, d) || f_dst(b) == d)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset;
    q.delete();
    m_busy = '0; e_av = 0; e_mv = 0;
    e_apc = '0; e_ai = '0; e_mpc = '0; e_mi = '0; e_ic = '0; e_dc = '0;
  endtask

  task automatic chk_outs;
    chk("alu_valid", alu_valid, e_av);
    chk("alu_pc", alu_pc, e_apc);
    chk("alu_instr", alu_instr, e_ai);
    chk("mem_valid", mem_valid, e_mv);
    chk("mem_pc", mem_pc, e_mpc);
    chk("mem_instr", mem_instr, e_mi);
    chk("issue_cnt", issue_cnt, e_ic);
    chk("dual_cnt", dual_cnt, e_dc);
    chk("busy", dut.busy_q, m_busy);
  endtask

  // One clock cycle: drive, predict, check ready mid-cycle and registered outputs after the edge.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input logic awe, input logic [4:0] awa,
                      input logic mwe, input logic [4:0] mwa, input logic bt);
    int n;
    logic rdy;
    logic [31:0] setm, clrm;
    ent_t e;
    fetch_valid = fv; fetch_pc = pc; fetch_instr0 = i0; fetch_instr1 = i1;
    alu_wb_en = awe; alu_wb_addr = awa; mem_wb_en = mwe; mem_wb_addr = mwa;
    branch_taken = bt;
    n = 0;
    if (!bt && q.size() > 0 && !f_hz(q[0].instr)) begin
      n = 1;
      if (q.size() > 1 && f_pair_ok(q[0].instr, q[1].instr) && !f_hz(q[1].instr)) n = 2;
    end
    rdy = !bt && (n == q.size());
    @(negedge clk);
    chk("fetch_ready", fetch_ready, rdy);
    @(posedge clk);
    #1;
    e_av = 0; e_mv = 0; setm = '0; clrm = '0;
    for (int k = 0; k < n; k++) begin
      e = q.pop_front();
      if (f_mem(e.instr)) begin e_mv = 1; e_mpc = e.pc; e_mi = e.instr; end
      else begin e_av = 1; e_apc = e.pc; e_ai = e.instr; end
      if (f_dst(e.instr) != 0) setm[f_dst(e.instr)] = 1'b1;
    end
    if (awe && awa != 0) clrm[awa] = 1'b1;
    if (mwe && mwa != 0) clrm[mwa] = 1'b1;
    m_busy = (m_busy & ~clrm) | setm;
    e_ic = e_ic + CNT_W'(n);
    if (n == 2) e_dc = e_dc + 1'b1;
    if (bt) q.delete();
    else if (fv && rdy) begin
      q.push_back('{pc, i0});
      q.push_back('{pc + 32'd4, i1});
    end
    chk_outs();
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
    step(1, pc, i0, i1, 0, 0, 0, 0, 0);
  endtask
  task automatic idle(input logic awe, input logic [4:0] awa, input logic bt);
    step(0, 0, 0, 0, awe, awa, 0, 0, bt);
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops [9];
    logic [5:0] fns [4];
    logic [5:0] op;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25};
    op = ops[$urandom_range(8)];
    if (op == 6'h00)
      return r_op(5'($urandom_range(15)), 5'($urandom_range(15)), 5'($urandom_range(15)),
                  fns[$urandom_range(3)]);
    return i_op(op, 5'($urandom_range(15)), 5'($urandom_range(15)), 16'($urandom));
  endfunction

  initial begin
    rst_n = 0; fetch_valid = 0; fetch_pc = 0; fetch_instr0 = 0; fetch_instr1 = 0;
    alu_wb_en = 0; alu_wb_addr = 0; mem_wb_en = 0; mem_wb_addr = 0; branch_taken = 0;
    m_reset();
    #2;
    chk_outs();
    chk("reset_ready", fetch_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // lw $8 + add $9 dual issue at 0x40
    load(32'h40, i_op(6'h23, 8, 1, 0), r_op(9, 2, 3, 6'h20));
    idle(0, 0, 0);
    chk("lit_mem_valid", mem_valid, 1'b1);
    chk("lit_mem_pc", mem_pc, 32'h40);
    chk("lit_alu_valid", alu_valid, 1'b1);
    chk("lit_alu_pc", alu_pc, 32'h44);
    chk("lit_dual_cnt", dual_cnt, 4'd1);
    chk("lit_issue_cnt", issue_cnt, 4'd2);
    chk("lit_busy89", dut.busy_q & 32'h300, 32'h300);

    // s0 reads busy $8 -> stuck in buffer; reset asynchronously mid-cycle
    load(32'h80, r_op(10, 8, 1, 6'h20), r_op(11, 1, 2, 6'h20));
    idle(0, 0, 0);
    chk("lit_blocked_ready", fetch_ready, 1'b0);
    #2 rst_n = 0;
    #1;
    m_reset();
    chk_outs();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("lit_ready_after_rst", fetch_ready, 1'b1);

    // add $5 + sub $6,$5: sub waits for write-back of $5
    load(32'h100, r_op(5, 1, 2, 6'h20), r_op(6, 5, 3, 6'h22));
    idle(0, 0, 0);
    chk("lit_raw_alu_pc", alu_pc, 32'h100);
    chk("lit_raw_ready0", fetch_ready, 1'b0);
    idle(0, 0, 0);
    idle(1, 5, 0);
    chk("lit_raw_held", alu_valid, 1'b0);
    chk("lit_raw_ready1", fetch_ready, 1'b1);
    idle(0, 0, 0);
    chk("lit_raw_sub_valid", alu_valid, 1'b1);
    chk("lit_raw_sub_pc", alu_pc, 32'h104);

    // add + or, both ALU: serialised
    load(32'h0, r_op(11, 1, 2, 6'h20), r_op(12, 3, 4, 6'h25));
    idle(1, 6, 0);
    chk("lit_ser_pc0", alu_pc, 32'h0);
    idle(0, 0, 0);
    chk("lit_ser_valid1", alu_valid, 1'b1);
    chk("lit_ser_pc1", alu_pc, 32'h4);
    chk("lit_ser_dual", dual_cnt, 4'd0);
    chk("lit_ser_issue", issue_cnt, 4'd4);

    // beq + lw, flush right after beq issues
    load(32'h200, i_op(6'h04, 2, 1, 16'h10), i_op(6'h23, 13, 3, 0));
    idle(0, 0, 0);
    chk("lit_br_alu_pc", alu_pc, 32'h200);
    chk("lit_br_mem0", mem_valid, 1'b0);
    idle(0, 0, 1);
    chk("lit_br_mem1", mem_valid, 1'b0);
    idle(0, 0, 0);
    chk("lit_br_mem2", mem_valid, 1'b0);
    chk("lit_br_ready", fetch_ready, 1'b1);

    // addi $7 issues while $7 writes back: set wins; $0 destination never marked
    load(32'h300, i_op(6'h08, 7, 1, 16'h1), r_op(0, 1, 2, 6'h20));
    idle(1, 7, 0);
    chk("lit_setwins", dut.busy_q[7], 1'b1);
    idle(0, 0, 0);
    chk("lit_r0_issued", alu_pc, 32'h304);
    chk("lit_r0_busy", dut.busy_q[0], 1'b0);
    chk("lit_r7_busy", dut.busy_q[7], 1'b1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(9) < 7, $urandom & 32'hFFFF_FFFC, rnd_instr(), rnd_instr(),
           $urandom_range(1) == 1, 5'($urandom_range(15)),
           $urandom_range(1) == 1, 5'($urandom_range(15)),
           $urandom_range(19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
